// File: rtl/lud_pkg.sv
// Shared definitions for the LU-decomposition control path.
//   - Default widths for the control word, the repeat field and the
//     instruction memory address.
//   - Instruction word layout: {rep, ctrl}, with the repeat field in the MSBs.
//   - Sequencer state encoding.
package lud_pkg;

    localparam int LUD_CTRL_WIDTH      = 60;
    localparam int LUD_REP_WIDTH       = 8;
    localparam int LUD_IMEM_ADDR_WIDTH = 10;
    localparam int LUD_WORD_WIDTH      = LUD_REP_WIDTH + LUD_CTRL_WIDTH;

    // The repeat field starts right above the control field.
    localparam int REP_LSB = LUD_CTRL_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/lud_ctrl_prefetch.sv
// Instruction fetch engine for lud_ctrl_sequencer.
// It holds the read address counter, a one-entry prefetch slot and the flag
// for a read whose data returns in the current cycle. The word offered to the
// sequencer comes from the slot when it is full. Otherwise it comes straight
// from the memory read data (bypass).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        drop the slot and any returning data, stop fetching
//   restart      accepted start: read address 0 now, continue from 1
//   consume      the sequencer takes the offered word this cycle
//   prog_last    address of the last instruction (latched by the sequencer)
//   imem_rd_en   read strobe to the instruction memory
//   imem_addr    read address to the instruction memory
//   imem_rdata   read data, valid one cycle after imem_rd_en
//   word         offered instruction word
//   word_valid   the offered word is real data
module lud_ctrl_prefetch
    import lud_pkg::*;
#(
    parameter int WORD_WIDTH = LUD_WORD_WIDTH,
    parameter int ADDR_WIDTH = LUD_IMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  restart,
    input  logic                  consume,
    input  logic [ADDR_WIDTH-1:0] prog_last,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid
);

    logic [WORD_WIDTH-1:0] pf_r;
    logic                  pf_valid_r;
    logic                  rd_pending_r;
    // One bit wider than the address so the counter can step past an
    // all-ones prog_last instead of wrapping back to 0.
    logic [ADDR_WIDTH:0]   next_addr_r;
    logic                  in_range_s;
    logic                  occupied_s;

    assign word       = pf_valid_r ? pf_r : imem_rdata;
    assign word_valid = pf_valid_r | rd_pending_r;

    // Read issue: a restart always reads address 0. Otherwise a read is
    // issued only when the slot plus in-flight data will be empty after
    // this cycle's consume.
    always_comb begin
        in_range_s = (next_addr_r <= {1'b0, prog_last});
        occupied_s = (pf_valid_r | rd_pending_r) & ~consume;
        imem_rd_en = 1'b0;
        imem_addr  = '0;
        if (flush) begin
            imem_rd_en = 1'b0;
        end else if (restart) begin
            imem_rd_en = 1'b1;
        end else if (in_range_s && !occupied_s) begin
            imem_rd_en = 1'b1;
            imem_addr  = next_addr_r[ADDR_WIDTH-1:0];
        end else begin
            imem_rd_en = 1'b0;
        end
    end

    // Prefetch slot, returning-data flag and fetch address counter.
    // While parked, the counter is all-ones, which is above any prog_last.
    // This way no stale read can fire between programs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_r         <= '0;
            pf_valid_r   <= 1'b0;
            rd_pending_r <= 1'b0;
            next_addr_r  <= {(ADDR_WIDTH + 1){1'b1}};
        end else if (flush) begin
            pf_valid_r   <= 1'b0;
            rd_pending_r <= 1'b0;
            next_addr_r  <= {(ADDR_WIDTH + 1){1'b1}};
        end else begin
            rd_pending_r <= imem_rd_en;
            if (restart) begin
                next_addr_r <= (ADDR_WIDTH + 1)'(1'b1);
            end else if (imem_rd_en) begin
                next_addr_r <= next_addr_r + (ADDR_WIDTH + 1)'(1'b1);
            end
            // Returning data is parked unless the bypass takes it right now.
            if (rd_pending_r && (pf_valid_r || !consume)) begin
                pf_r       <= imem_rdata;
                pf_valid_r <= 1'b1;
            end else if (consume) begin
                pf_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lud_ctrl_sequencer.sv
// Control-word sequencer feeding LUDHardware.
// It plays a pre-compiled program from the instruction memory. It drives one
// control word per clock, and holds each word for rep+1 cycles.
// Ports:
//   CLK_100, RST  clock, synchronous active-high reset
//   start         pulse that begins a program (ignored while busy)
//   abort         synchronous stop, wins over start
//   prog_last     address of the last instruction, sampled on accepted start
//   imem_rd_en    instruction memory read strobe
//   imem_addr     instruction memory read address
//   imem_rdata    instruction memory read data, {rep, ctrl}
//   CTRL_Signal   registered control word to the datapath
//   cur_addr      address of the word currently on CTRL_Signal
//   busy          program in progress
//   done          one-cycle pulse on normal completion
module lud_ctrl_sequencer
    import lud_pkg::*;
#(
    parameter int CTRL_WIDTH      = LUD_CTRL_WIDTH,
    parameter int REP_WIDTH       = LUD_REP_WIDTH,
    parameter int IMEM_ADDR_WIDTH = LUD_IMEM_ADDR_WIDTH
) (
    input  logic                            CLK_100,
    input  logic                            RST,
    input  logic                            start,
    input  logic                            abort,
    input  logic [IMEM_ADDR_WIDTH-1:0]      prog_last,
    output logic                            imem_rd_en,
    output logic [IMEM_ADDR_WIDTH-1:0]      imem_addr,
    input  logic [CTRL_WIDTH+REP_WIDTH-1:0] imem_rdata,
    output logic [CTRL_WIDTH-1:0]           CTRL_Signal,
    output logic [IMEM_ADDR_WIDTH-1:0]      cur_addr,
    output logic                            busy,
    output logic                            done
);

    localparam int WORD_WIDTH = CTRL_WIDTH + REP_WIDTH;

    seq_state_e                 state_r, state_nxt_s;
    logic [CTRL_WIDTH-1:0]      ctrl_r, ctrl_nxt_s;
    logic [REP_WIDTH-1:0]       rep_cnt_r, rep_nxt_s;
    logic [IMEM_ADDR_WIDTH-1:0] cur_addr_r, cur_nxt_s;
    logic [IMEM_ADDR_WIDTH-1:0] last_r, last_nxt_s;
    logic                       busy_r, busy_nxt_s;
    logic                       done_r, done_nxt_s;
    logic                       start_ok_s;
    logic                       consume_s;
    logic                       flush_s;
    logic [WORD_WIDTH-1:0]      word_s;
    logic                       word_valid_s;

    assign flush_s     = RST | abort;
    assign CTRL_Signal = ctrl_r;
    assign cur_addr    = cur_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;

    lud_ctrl_prefetch #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (IMEM_ADDR_WIDTH)
    ) u_prefetch (
        .clk        (CLK_100),
        .rst        (RST),
        .flush      (flush_s),
        .restart    (start_ok_s),
        .consume    (consume_s),
        .prog_last  (last_r),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state and next-output decode for the IDLE/PRIME/RUN sequencer.
    always_comb begin
        state_nxt_s = state_r;
        ctrl_nxt_s  = ctrl_r;
        rep_nxt_s   = rep_cnt_r;
        cur_nxt_s   = cur_addr_r;
        last_nxt_s  = last_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        start_ok_s  = 1'b0;
        consume_s   = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            ctrl_nxt_s  = '0;
            rep_nxt_s   = '0;
            cur_nxt_s   = '0;
            busy_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_ok_s  = 1'b1;
                        last_nxt_s  = prog_last;
                        busy_nxt_s  = 1'b1;
                        state_nxt_s = ST_PRIME;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    // Word 0 arrives on the bypass in this cycle.
                    consume_s   = 1'b1;
                    ctrl_nxt_s  = word_s[CTRL_WIDTH-1:0];
                    rep_nxt_s   = word_s[WORD_WIDTH-1:CTRL_WIDTH];
                    cur_nxt_s   = '0;
                    state_nxt_s = ST_RUN;
                end
                ST_RUN: begin
                    if (rep_cnt_r != '0) begin
                        rep_nxt_s = rep_cnt_r - REP_WIDTH'(1'b1);
                    end else if (cur_addr_r == last_r) begin
                        ctrl_nxt_s  = '0;
                        rep_nxt_s   = '0;
                        cur_nxt_s   = '0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (word_valid_s) begin
                        consume_s  = 1'b1;
                        ctrl_nxt_s = word_s[CTRL_WIDTH-1:0];
                        rep_nxt_s  = word_s[WORD_WIDTH-1:CTRL_WIDTH];
                        cur_nxt_s  = cur_addr_r + IMEM_ADDR_WIDTH'(1'b1);
                    end else begin
                        // Next word not yet available: hold the current one.
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    ctrl_nxt_s  = '0;
                    rep_nxt_s   = '0;
                    cur_nxt_s   = '0;
                    busy_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge CLK_100) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            ctrl_r     <= '0;
            rep_cnt_r  <= '0;
            cur_addr_r <= '0;
            last_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            rep_cnt_r  <= rep_nxt_s;
            cur_addr_r <= cur_nxt_s;
            last_r     <= last_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_lud_ctrl_sequencer.sv
// Self-checking bench for lud_ctrl_sequencer (4-bit instruction addresses).
module tb_lud_ctrl_sequencer;

    localparam int CW = 60;
    localparam int RW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [AW-1:0]   prog_last;
    logic            imem_rd_en;
    logic [AW-1:0]   imem_addr;
    logic [RW+CW-1:0] imem_rdata;
    logic [CW-1:0]   ctrl_sig;
    logic [AW-1:0]   cur_addr;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [RW+CW-1:0] mem [16];
    int               rep_tab [16];
    int unsigned      rd_log [$];

    lud_ctrl_sequencer #(
        .CTRL_WIDTH      (CW),
        .REP_WIDTH       (RW),
        .IMEM_ADDR_WIDTH (AW)
    ) dut (
        .CLK_100     (clk),
        .RST         (rst),
        .start       (start),
        .abort       (abort),
        .prog_last   (prog_last),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .CTRL_Signal (ctrl_sig),
        .cur_addr    (cur_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Instruction memory: 1-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (imem_rd_en) begin
            imem_rdata <= mem[imem_addr];
            rd_log.push_back(imem_addr);
        end else begin
            imem_rdata <= {8'h77, 60'hBADBADBADBADBAD};
        end
    end

    function automatic logic [CW-1:0] ctrl_of(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {4'hA, 12'h5C3, 36'h0, b ^ 8'h3C};
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 16; i++) mem[i] = {RW'(rep_tab[i]), ctrl_of(i)};
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          start;
        logic          abort;
        logic          exp_rd;
        logic [AW-1:0] exp_addr;
        logic [CW-1:0] exp_ctrl;
        logic [AW-1:0] exp_cur;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t vecs [14];

    // Start a program at word 0..last and compare against the rep table.
    task automatic run_program(input string nm, input int last);
        logic [CW-1:0] exp_ctrl [$];
        int            exp_cur [$];
        int            total;
        for (int i = 0; i <= last; i++)
            for (int r = 0; r <= rep_tab[i]; r++) begin
                exp_ctrl.push_back(ctrl_of(i));
                exp_cur.push_back(i);
            end
        total = exp_ctrl.size();
        rd_log.delete();
        @(negedge clk);
        prog_last = AW'(last);
        start = 1'b1;
        #1;
        chk({nm, ".start_rd"}, imem_rd_en, 1);
        chk({nm, ".start_addr"}, imem_addr, 0);
        for (int c = 1; c <= total + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) prog_last = ~prog_last;
            #1;
            if (c == 1) begin
                chk($sformatf("%s.c%0d.busy", nm, c), busy, 1);
                chk($sformatf("%s.c%0d.ctrl", nm, c), ctrl_sig, 0);
            end else if (c < 2 + total) begin
                chk($sformatf("%s.c%0d.ctrl", nm, c), ctrl_sig, exp_ctrl[c-2]);
                chk($sformatf("%s.c%0d.cur", nm, c), cur_addr, exp_cur[c-2]);
                chk($sformatf("%s.c%0d.busy", nm, c), busy, 1);
                chk($sformatf("%s.c%0d.done", nm, c), done, 0);
            end else if (c == 2 + total) begin
                chk($sformatf("%s.c%0d.done", nm, c), done, 1);
                chk($sformatf("%s.c%0d.ctrl", nm, c), ctrl_sig, 0);
                chk($sformatf("%s.c%0d.busy", nm, c), busy, 0);
            end else begin
                chk($sformatf("%s.c%0d.done", nm, c), done, 0);
                chk($sformatf("%s.c%0d.busy", nm, c), busy, 0);
            end
        end
        chk({nm, ".nreads"}, rd_log.size(), last + 1);
        for (int i = 0; i < rd_log.size() && i <= last; i++)
            chk($sformatf("%s.rd%0d", nm, i), rd_log[i], i);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prog_last = '0;
        for (int i = 0; i < 16; i++) rep_tab[i] = 0;
        load_mem();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rd_en", imem_rd_en, 0);
        chk("rst.addr", imem_addr, 0);
        chk("rst.ctrl", ctrl_sig, 0);
        chk("rst.cur", cur_addr, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3-word program, start while busy, back-to-back restart,
        // then start+abort in the same cycle.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd0, '0,         4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd1, '0,         4'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd2, ctrl_of(0), 4'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, ctrl_of(1), 4'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, ctrl_of(2), 4'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd0, '0,         4'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd1, '0,         4'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd2, ctrl_of(0), 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, ctrl_of(1), 4'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, ctrl_of(2), 4'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,         4'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,         4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd0, '0,         4'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0, '0,         4'd0, 1'b0, 1'b0};
        prog_last = 4'd2;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start = vecs[k].start;
            abort = vecs[k].abort;
            #1;
            chk($sformatf("vec%0d.rd_en", k), imem_rd_en, vecs[k].exp_rd);
            chk($sformatf("vec%0d.addr", k), imem_addr, vecs[k].exp_addr);
            chk($sformatf("vec%0d.ctrl", k), ctrl_sig, vecs[k].exp_ctrl);
            chk($sformatf("vec%0d.cur", k), cur_addr, vecs[k].exp_cur);
            chk($sformatf("vec%0d.busy", k), busy, vecs[k].exp_busy);
            chk($sformatf("vec%0d.done", k), done, vecs[k].exp_done);
        end
        start = 1'b0; abort = 1'b0;

        // Repeat field: word0 held 5 cycles, then word1
        rep_tab[0] = 4; rep_tab[1] = 0; load_mem();
        run_program("repeat", 1);

        // Single word
        rep_tab[0] = 0; load_mem();
        run_program("single", 0);

        // Mixed repeats, slot refill after a held word
        rep_tab[0] = 0; rep_tab[1] = 2; rep_tab[2] = 0; rep_tab[3] = 1; load_mem();
        run_program("mixed", 3);

        // Abort in the second RUN cycle, then replay
        for (int i = 0; i < 16; i++) rep_tab[i] = 0;
        load_mem();
        @(negedge clk); prog_last = 4'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1; #1;
        chk("abort.pre_ctrl", ctrl_sig, ctrl_of(1));
        @(negedge clk); abort = 1'b0; #1;
        chk("abort.ctrl", ctrl_sig, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.cur", cur_addr, 0);
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk); #1;
            chk($sformatf("abort.c%0d.done", c), done, 0);
            chk($sformatf("abort.c%0d.rd_en", c), imem_rd_en, 0);
            chk($sformatf("abort.c%0d.ctrl", c), ctrl_sig, 0);
        end
        run_program("replay", 3);

        // Full address space, no bubble, no wrap to address 0
        run_program("edge16", 15);

        // RST in the middle of a program
        @(negedge clk); prog_last = 4'd15; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rstmid.rd_en", imem_rd_en, 0);
        chk("rstmid.addr", imem_addr, 0);
        chk("rstmid.ctrl", ctrl_sig, 0);
        chk("rstmid.cur", cur_addr, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.done", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rstmid.idle%0d.rd_en", c), imem_rd_en, 0);
            chk($sformatf("rstmid.idle%0d.done", c), done, 0);
        end
        run_program("post_rst", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
